mc_bus_bridge: RTL and testbench

MC_BUS_BRIDGE -- requirements
Module: mc_bus_bridge

---
 rtl/mc_bus_bridge.sv | 128 ++++++++++++
 tb/tb_mc_bus_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_bus_bridge.sv
// Bridges micro-controller loads/stores above 0x1000_0000 onto a single-outstanding
// req/ack external bus. Optional ack timeout enabled by defining MCB_TIMEOUT_EN.
`ifndef ACCESS_CODE
`define ACCESS_CODE  2'd0
`endif
`ifndef ACCESS_READ
`define ACCESS_READ  2'd1
`endif
`ifndef ACCESS_WRITE
`define ACCESS_WRITE 2'd2
`endif

module mc_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  w_mic_req,
  input  logic [31:0] w_mic_addr,
  input  logic [31:0] w_mic_wdata,
  input  logic [2:0]  w_mic_ctrl,
  input  logic        w_mic_mmuwe,
  output logic        w_stall,
  output logic [31:0] w_data,
  output logic        w_bus_req,
  output logic        w_bus_we,
  output logic [31:0] w_bus_addr,
  output logic [31:0] w_bus_wdata,
  output logic [2:0]  w_bus_ctrl,
  input  logic        w_bus_ack,
  input  logic [31:0] w_bus_rdata,
  output logic        w_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, data_q, data_d;
  logic [2:0]  ctrl_q;
  logic        we_q;
  logic        ext_req, stall;

  // Only the low 256MB is local memory; everything above goes out on the bus.
  assign ext_req = (state_q == S_IDLE) && (|w_mic_addr[31:28]) &&
                   ((w_mic_req == `ACCESS_READ) ||
                    ((w_mic_req == `ACCESS_WRITE) && w_mic_mmuwe));

`ifdef MCB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    stall   = 1'b0;
`ifdef MCB_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      S_IDLE: if (ext_req) begin
        stall   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (w_bus_ack) begin
          state_d = S_DONE;
          if (!we_q) data_d = w_bus_rdata;
        end
`ifdef MCB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!we_q) data_d = 32'hDEADBEEF;
        end
`endif
      end
      // The micro controller still shows its request here; release it without re-issuing.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
`ifdef MCB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (ext_req) begin
        addr_q  <= w_mic_addr;
        wdata_q <= w_mic_wdata;
        ctrl_q  <= w_mic_ctrl;
        we_q    <= (w_mic_req == `ACCESS_WRITE);
      end
`ifdef MCB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign w_stall     = stall & ~RST;
  assign w_data      = data_q;
  assign w_bus_req   = (state_q == S_WAIT);
  assign w_bus_we    = we_q;
  assign w_bus_addr  = addr_q;
  assign w_bus_wdata = wdata_q;
  assign w_bus_ctrl  = ctrl_q;
`ifdef MCB_TIMEOUT_EN
  assign w_bus_err   = err_q;
`else
  assign w_bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mc_bus_bridge.sv
// Scoreboard bench for mc_bus_bridge: drivers queue expected bus requests and
// completions, a negedge monitor pops and compares them as the DUT presents them.
`ifndef ACCESS_CODE
`define ACCESS_CODE  2'd0
`endif
`ifndef ACCESS_READ
`define ACCESS_READ  2'd1
`endif
`ifndef ACCESS_WRITE
`define ACCESS_WRITE 2'd2
`endif

module tb_mc_bus_bridge;
  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  w_mic_req;
  logic [31:0] w_mic_addr, w_mic_wdata;
  logic [2:0]  w_mic_ctrl;
  logic        w_mic_mmuwe;
  logic        w_stall;
  logic [31:0] w_data;
  logic        w_bus_req, w_bus_we;
  logic [31:0] w_bus_addr, w_bus_wdata;
  logic [2:0]  w_bus_ctrl;
  logic        w_bus_ack;
  logic [31:0] w_bus_rdata;
  logic        w_bus_err;

  always #5 CLK = ~CLK;

  mc_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .w_mic_req(w_mic_req), .w_mic_addr(w_mic_addr), .w_mic_wdata(w_mic_wdata),
    .w_mic_ctrl(w_mic_ctrl), .w_mic_mmuwe(w_mic_mmuwe),
    .w_stall(w_stall), .w_data(w_data),
    .w_bus_req(w_bus_req), .w_bus_we(w_bus_we), .w_bus_addr(w_bus_addr),
    .w_bus_wdata(w_bus_wdata), .w_bus_ctrl(w_bus_ctrl),
    .w_bus_ack(w_bus_ack), .w_bus_rdata(w_bus_rdata), .w_bus_err(w_bus_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    int          req_len;
  } bus_t;

  typedef struct {
    int          stall_len;
    logic [31:0] data;
    logic        err;
  } done_t;

  bus_t  exp_bus[$];
  done_t exp_done[$];
  int    n_cmp = 0, n_err = 0, bus_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor
  bus_t  mb;
  done_t md;
  int    req_len = 0, stall_len = 0, cur_req_exp = 0;
  logic  prev_req = 1'b0, prev_stall = 1'b0;

  always @(negedge CLK) begin
    if (RST) begin
      req_len = 0; stall_len = 0; prev_req = 1'b0; prev_stall = 1'b0;
    end else begin
      if (w_bus_req && !prev_req) begin
        bus_cnt++;
        if (exp_bus.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL bus_unexpected: got request addr %h expected none", w_bus_addr);
        end else begin
          mb = exp_bus.pop_front();
          check("bus_we",    {31'd0, w_bus_we}, {31'd0, mb.we});
          check("bus_addr",  w_bus_addr, mb.addr);
          check("bus_wdata", w_bus_wdata, mb.wdata);
          check("bus_ctrl",  {29'd0, w_bus_ctrl}, {29'd0, mb.ctrl});
          cur_req_exp = mb.req_len;
        end
      end
      if (w_bus_req) req_len++;
      if (!w_bus_req && prev_req) begin
        check("bus_req_len", req_len, cur_req_exp);
        req_len = 0;
      end
      if (w_stall) stall_len++;
      if (!w_stall && prev_stall) begin
        if (exp_done.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done_unexpected: got stall release after %0d cycles expected none", stall_len);
        end else begin
          md = exp_done.pop_front();
          check("stall_len", stall_len, md.stall_len);
          check("done_data", w_data, md.data);
          check("done_err",  {31'd0, w_bus_err}, {31'd0, md.err});
        end
        stall_len = 0;
      end
      prev_req   = w_bus_req;
      prev_stall = w_stall;
    end
  end

  task automatic set_mic(input logic [1:0] rq, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] c, input logic we);
    w_mic_req = rq; w_mic_addr = a; w_mic_wdata = wd; w_mic_ctrl = c; w_mic_mmuwe = we;
  endtask

  // External transfer: nwait WAIT cycles, ack in the last one (if give_ack).
  task automatic xfer(input logic [1:0] rq, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] c, input logic we, input int nwait, input logic give_ack,
                      input logic [31:0] rd, input logic [31:0] exp_d, input logic exp_err);
    bus_t  b;
    done_t d;
    b.we = (rq == `ACCESS_WRITE); b.addr = a; b.wdata = wd; b.ctrl = c; b.req_len = nwait;
    exp_bus.push_back(b);
    d.stall_len = nwait + 1; d.data = exp_d; d.err = exp_err;
    exp_done.push_back(d);
    set_mic(rq, a, wd, c, we);
    repeat (nwait) @(posedge CLK) #1;
    if (give_ack) begin w_bus_ack = 1'b1; w_bus_rdata = rd; end
    @(posedge CLK) #1;
    w_bus_ack = 1'b0; w_bus_rdata = 32'h0;
    @(posedge CLK) #1;
    w_mic_req = 2'd3;
  endtask

  logic [1:0]  lv_req   [5] = '{`ACCESS_READ, `ACCESS_WRITE, `ACCESS_CODE, `ACCESS_WRITE, 2'd3};
  logic [31:0] lv_addr  [5] = '{32'h0000_0100, 32'h0000_0200, 32'h8000_0000, 32'h8000_0040, 32'h8000_0000};
  logic        lv_mmuwe [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int bc0;
    RST = 1'b1; w_bus_ack = 1'b0; w_bus_rdata = 32'h0;
    set_mic(`ACCESS_READ, 32'h8000_0010, 32'h0, 3'b010, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_stall",   {31'd0, w_stall},   32'd0);
    check("rst_bus_req", {31'd0, w_bus_req}, 32'd0);
    check("rst_bus_we",  {31'd0, w_bus_we},  32'd0);
    check("rst_addr",    w_bus_addr,  32'd0);
    check("rst_wdata",   w_bus_wdata, 32'd0);
    check("rst_ctrl",    {29'd0, w_bus_ctrl}, 32'd0);
    check("rst_data",    w_data, 32'd0);
    check("rst_err",     {31'd0, w_bus_err}, 32'd0);
    w_mic_req = 2'd3;
    @(posedge CLK) #1;
    RST = 1'b0;
    @(posedge CLK) #1;

    xfer(`ACCESS_READ,  32'h8000_0010, 32'h0,         3'b010, 1'b0, 3, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0);
    xfer(`ACCESS_WRITE, 32'h4000_0004, 32'hCAFE_BABE, 3'b010, 1'b1, 1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);

    for (int i = 0; i < 5; i++) begin
      set_mic(lv_req[i], lv_addr[i], 32'h5555_AAAA, 3'b000, lv_mmuwe[i]);
      repeat (3) begin
        @(negedge CLK);
        check("local_stall",   {31'd0, w_stall},   32'd0);
        check("local_bus_req", {31'd0, w_bus_req}, 32'd0);
      end
      @(posedge CLK) #1;
    end
    w_mic_req = 2'd3;

    bc0 = bus_cnt;
    xfer(`ACCESS_READ, 32'h8000_1000, 32'h0, 3'b000, 1'b0, 1, 1'b1, 32'h11, 32'h11, 1'b0);
    xfer(`ACCESS_READ, 32'h8000_2000, 32'h0, 3'b100, 1'b0, 2, 1'b1, 32'h22, 32'h22, 1'b0);
    @(negedge CLK);
    check("b2b_req_count", bus_cnt - bc0, 32'd2);

    // Ack while idle must not touch the data register
    @(posedge CLK) #1;
    w_bus_ack = 1'b1; w_bus_rdata = 32'h99;
    @(posedge CLK) #1;
    w_bus_ack = 1'b0;
    @(negedge CLK);
    check("idle_ack_data",  w_data, 32'h22);
    check("idle_ack_stall", {31'd0, w_stall}, 32'd0);
    @(posedge CLK) #1;

    begin : mid_wait_reset
      bus_t b;
      b.we = 1'b0; b.addr = 32'h8000_0020; b.wdata = 32'h0; b.ctrl = 3'b010; b.req_len = 0;
      exp_bus.push_back(b);
    end
    set_mic(`ACCESS_READ, 32'h8000_0020, 32'h0, 3'b010, 1'b0);
    @(posedge CLK) #1;
    @(posedge CLK) #1;
    RST = 1'b1; w_mic_req = 2'd3;
    @(negedge CLK);
    check("rstmid_stall", {31'd0, w_stall}, 32'd0);
    @(posedge CLK) #1;
    RST = 1'b0; w_bus_ack = 1'b1; w_bus_rdata = 32'h55;
    @(negedge CLK);
    check("rstmid_req", {31'd0, w_bus_req}, 32'd0);
    @(posedge CLK) #1;
    w_bus_ack = 1'b0;
    @(negedge CLK);
    check("rstmid_data",  w_data, 32'd0);
    check("rstmid_req2",  {31'd0, w_bus_req}, 32'd0);
    check("rstmid_stall2", {31'd0, w_stall}, 32'd0);
    @(posedge CLK) #1;

`ifdef MCB_TIMEOUT_EN
    xfer(`ACCESS_READ, 32'h8000_0030, 32'h0, 3'b010, 1'b0, TO, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    xfer(`ACCESS_READ, 32'h8000_0034, 32'h0, 3'b010, 1'b0, 2, 1'b1, 32'h77, 32'h77, 1'b1);
`else
    begin : no_ack
      bus_t b;
      b.we = 1'b0; b.addr = 32'h8000_0030; b.wdata = 32'h0; b.ctrl = 3'b010; b.req_len = 0;
      exp_bus.push_back(b);
    end
    set_mic(`ACCESS_READ, 32'h8000_0030, 32'h0, 3'b010, 1'b0);
    repeat (20) @(posedge CLK) #1;
    @(negedge CLK);
    check("noack_req",   {31'd0, w_bus_req}, 32'd1);
    check("noack_stall", {31'd0, w_stall},   32'd1);
    check("noack_err",   {31'd0, w_bus_err}, 32'd0);
    check("noack_data",  w_data, 32'd0);
    @(posedge CLK) #1;
    RST = 1'b1; w_mic_req = 2'd3;
    @(posedge CLK) #1;
    RST = 1'b0;
    xfer(`ACCESS_READ, 32'h8000_0034, 32'h0, 3'b010, 1'b0, 2, 1'b1, 32'h77, 32'h77, 1'b0);
`endif

    RST = 1'b1;
    @(posedge CLK) #1;
    RST = 1'b0;
    @(negedge CLK);
    check("final_rst_err",  {31'd0, w_bus_err}, 32'd0);
    check("final_rst_data", w_data, 32'd0);
    check("bus_queue_left",  exp_bus.size(),  32'd0);
    check("done_queue_left", exp_done.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

endmodule
